// File: rtl/pattern_pkg.sv
// Shared definitions for the pattern serializer: default sizing, FSM state
// encoding and the bit-order selector values.
package pattern_pkg;

    localparam int DEFAULT_WIDTH      = 32;
    localparam int DEFAULT_BIT_CYCLES = 1;

    localparam bit LSB_FIRST_ENC = 1'b0;
    localparam bit MSB_FIRST_ENC = 1'b1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/pattern_bit_timer.sv
// Per-bit dwell timer: counts 0..BIT_CYCLES-1 while enabled and flags the last
// cycle of each bit with bit_end.
module pattern_bit_timer #(
    parameter int BIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic bit_end
);

    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CYCLE = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] cycle_cnt;

    assign bit_end = enable && (cycle_cnt == LAST_CYCLE);

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            cycle_cnt <= '0;
        end else if (bit_end) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/pattern_serializer.sv
// Parallel-to-serial front end for the pattern detectors: a shift register plus
// one holding register so consecutive words stream out without an idle bit.
//
// state | meaning
// IDLE  | shift register empty, x_valid low, holding register empty
// SHIFT | a word is being shifted out on x; holding register may be full
module pattern_serializer
    import pattern_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int BIT_CYCLES = DEFAULT_BIT_CYCLES,
    parameter bit MSB_FIRST  = MSB_FIRST_ENC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] hold_reg;
    logic             hold_full;
    logic [BW-1:0]    bit_cnt;
    logic             bit_end;
    logic             word_end;
    logic             accept;
    logic [WIDTH-1:0] shreg_next;

    pattern_bit_timer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_bit_timer (
        .clk     (clk),
        .rst     (rst),
        .enable  (state == SHIFT),
        .bit_end (bit_end)
    );

    // The head bit sits at the end of the register that shifts out first.
    assign shreg_next = (MSB_FIRST == MSB_FIRST_ENC) ? {shreg[WIDTH-2:0], 1'b0}
                                                     : {1'b0, shreg[WIDTH-1:1]};

    assign load_ready = !hold_full;
    assign accept     = load_valid && load_ready;
    assign word_end   = (state == SHIFT) && bit_end && (bit_cnt == LAST_BIT);

    assign x_valid = (state == SHIFT);
    assign x       = (state == SHIFT) &&
                     ((MSB_FIRST == MSB_FIRST_ENC) ? shreg[WIDTH-1] : shreg[0]);
    assign busy    = (state == SHIFT) || hold_full;
    assign done    = word_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            hold_reg  <= '0;
            hold_full <= 1'b0;
            bit_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg   <= din;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (word_end) begin
                        bit_cnt <= '0;
                        // load_ready is low while hold_full, so accept cannot
                        // coincide with a handoff from the holding register.
                        if (hold_full) begin
                            shreg     <= hold_reg;
                            hold_full <= 1'b0;
                        end else if (accept) begin
                            shreg <= din;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        if (bit_end) begin
                            shreg   <= shreg_next;
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                        if (accept) begin
                            hold_reg  <= din;
                            hold_full <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_serializer.sv
// Directed bench for pattern_serializer: a 32-bit MSB-first instance with
// single-cycle bits and an 8-bit LSB-first instance holding each bit 3 cycles.
module tb_pattern_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic        rst32, lv32, lr32, x32, xv32, busy32, done32;
    logic [31:0] din32;
    logic        rst8, lv8, lr8, x8, xv8, busy8, done8;
    logic [7:0]  din8;

    pattern_serializer #(.WIDTH(32), .BIT_CYCLES(1), .MSB_FIRST(1'b1)) dut32 (
        .clk        (clk),
        .rst        (rst32),
        .din        (din32),
        .load_valid (lv32),
        .load_ready (lr32),
        .x          (x32),
        .x_valid    (xv32),
        .busy       (busy32),
        .done       (done32)
    );

    pattern_serializer #(.WIDTH(8), .BIT_CYCLES(3), .MSB_FIRST(1'b0)) dut8 (
        .clk        (clk),
        .rst        (rst8),
        .din        (din8),
        .load_valid (lv8),
        .load_ready (lr8),
        .x          (x8),
        .x_valid    (xv8),
        .busy       (busy8),
        .done       (done8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] w32a;
        logic [31:0] w32b;
        logic [7:0]  w8a;
        logic [7:0]  w8b;
        logic        ebit;

        // 1: reset with load_valid held high
        rst32 = 1'b1; lv32 = 1'b1; din32 = 32'hFFFF_FFFF;
        rst8  = 1'b1; lv8  = 1'b1; din8  = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("rst x c%0d", k), x32, 0);
            chk($sformatf("rst x_valid c%0d", k), xv32, 0);
            chk($sformatf("rst busy c%0d", k), busy32, 0);
            chk($sformatf("rst done c%0d", k), done32, 0);
            chk($sformatf("rst load_ready c%0d", k), lr32, 1);
            chk($sformatf("rst8 x_valid c%0d", k), xv8, 0);
            chk($sformatf("rst8 load_ready c%0d", k), lr8, 1);
        end
        tick();
        rst32 = 1'b0; lv32 = 1'b0;
        rst8  = 1'b0; lv8  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk($sformatf("post-rst x_valid c%0d", k), xv32, 0);
            chk($sformatf("post-rst busy c%0d", k), busy32, 0);
        end

        // 2: single word, MSB first, one cycle per bit
        tick();
        w32a = 32'hF6D3_5BDB;
        din32 = w32a; lv32 = 1'b1;
        tick();
        lv32 = 1'b0;
        for (int c = 1; c <= 33; c++) begin
            @(negedge clk);
            if (c <= 32) begin
                ebit = w32a[32-c];
                chk($sformatf("t2 x c%0d", c), x32, ebit);
                chk($sformatf("t2 x_valid c%0d", c), xv32, 1);
                chk($sformatf("t2 busy c%0d", c), busy32, 1);
            end else begin
                chk("t2 x_valid after", xv32, 0);
                chk("t2 busy after", busy32, 0);
                chk("t2 x after", x32, 0);
            end
            chk($sformatf("t2 done c%0d", c), done32, (c == 32));
            tick();
        end

        // 3: back-to-back words, second one buffered in the holding register
        w32a = 32'hAAAA_AAAA;
        w32b = 32'h0000_FFFF;
        din32 = w32a; lv32 = 1'b1;
        tick();
        for (int c = 1; c <= 65; c++) begin
            if (c == 1) din32 = w32b;
            if (c == 2) lv32 = 1'b0;
            @(negedge clk);
            if (c <= 32) ebit = w32a[32-c];
            else if (c <= 64) ebit = w32b[64-c];
            else ebit = 1'b0;
            chk($sformatf("t3 x c%0d", c), x32, ebit);
            chk($sformatf("t3 x_valid c%0d", c), xv32, (c <= 64));
            chk($sformatf("t3 done c%0d", c), done32, (c == 32 || c == 64));
            chk($sformatf("t3 load_ready c%0d", c), lr32, !(c >= 2 && c <= 32));
            chk($sformatf("t3 busy c%0d", c), busy32, (c <= 64));
            tick();
        end

        // 4: 8-bit LSB first, three cycles per bit
        w8a = 8'h96;
        din8 = w8a; lv8 = 1'b1;
        tick();
        lv8 = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (c <= 24) ebit = w8a[(c-1)/3];
            else ebit = 1'b0;
            chk($sformatf("t4 x c%0d", c), x8, ebit);
            chk($sformatf("t4 x_valid c%0d", c), xv8, (c <= 24));
            chk($sformatf("t4 done c%0d", c), done8, (c == 24));
            chk($sformatf("t4 busy c%0d", c), busy8, (c <= 24));
            tick();
        end

        // 5: new word offered in the done cycle with the holding register empty
        w8a = 8'hC3;
        w8b = 8'h5A;
        din8 = w8a; lv8 = 1'b1;
        tick();
        lv8 = 1'b0;
        for (int c = 1; c <= 49; c++) begin
            if (c == 24) begin din8 = w8b; lv8 = 1'b1; end
            if (c == 25) lv8 = 1'b0;
            @(negedge clk);
            if (c <= 24) ebit = w8a[(c-1)/3];
            else if (c <= 48) ebit = w8b[(c-25)/3];
            else ebit = 1'b0;
            chk($sformatf("t5 x c%0d", c), x8, ebit);
            chk($sformatf("t5 x_valid c%0d", c), xv8, (c <= 48));
            chk($sformatf("t5 done c%0d", c), done8, (c == 24 || c == 48));
            chk($sformatf("t5 load_ready c%0d", c), lr8, 1);
            tick();
        end

        // 6: reset while shifting bit 10 with a second word held
        w32a = 32'h1234_5678;
        w32b = 32'hFFFF_FFFF;
        din32 = w32a; lv32 = 1'b1;
        tick();
        for (int c = 1; c <= 80; c++) begin
            if (c == 1)  din32 = w32b;
            if (c == 2)  lv32 = 1'b0;
            if (c == 11) rst32 = 1'b1;
            if (c == 12) rst32 = 1'b0;
            @(negedge clk);
            if (c <= 11) begin
                ebit = w32a[32-c];
                chk($sformatf("t6 x c%0d", c), x32, ebit);
                chk($sformatf("t6 x_valid c%0d", c), xv32, 1);
                chk($sformatf("t6 load_ready c%0d", c), lr32, (c == 1));
            end else begin
                chk($sformatf("t6 x c%0d", c), x32, 0);
                chk($sformatf("t6 x_valid c%0d", c), xv32, 0);
                chk($sformatf("t6 busy c%0d", c), busy32, 0);
                chk($sformatf("t6 load_ready c%0d", c), lr32, 1);
            end
            chk($sformatf("t6 done c%0d", c), done32, 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pattern_serializer.md
Name: pattern_serializer

Overview:
Parallel-to-serial front end for the serial pattern detectors. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit at a time on x. Its x output connects directly to the detector's x input. A two-entry buffer (active shift register plus holding register) allows back-to-back words to stream with no idle bit between them.

Parameters:
WIDTH, 32, word width in bits (must be >= 2)
BIT_CYCLES, 1, clock cycles each bit is held on x (must be >= 1)
MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
din  input  WIDTH  parallel word to serialize
load_valid  input  1  din is valid this cycle
load_ready  output  1  block can accept a word this cycle
x  output  1  serial bit, feeds the pattern detector x
x_valid  output  1  x carries a data bit this cycle
busy  output  1  a word is being shifted or is buffered
done  output  1  one-cycle pulse in the final cycle of each word's last bit

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous and active-high.
- Values while rst is sampled high: x=0, x_valid=0, busy=0, done=0, load_ready=1. Both buffer entries are emptied and the bit and cycle counters are cleared.
- Reset mid-word discards the active word and the held word. No done pulse is issued for a discarded word.
- Accept rule: a word is accepted on a rising edge where load_valid=1 and load_ready=1.
- load_ready: load_ready = !hold_full. It is driven from registered state only and has no combinational path from load_valid.
- Placement of an accepted word:
  - If the shifter is idle, or is in the final cycle of its last bit, the word goes straight into the shift register.
  - Otherwise the word goes into the holding register.
- Latency: the first bit appears on x with x_valid=1 in the cycle after acceptance.
- Bit timing:
  - Each bit is held for exactly BIT_CYCLES cycles.
  - A cycle counter runs 0..BIT_CYCLES-1 and wraps.
  - A bit counter runs 0..WIDTH-1.
  - Counter widths are $clog2 of the respective count, with a minimum of 1 bit.
- Bit order: MSB_FIRST=1 shifts left and presents bit WIDTH-1 first. MSB_FIRST=0 shifts right and presents bit 0 first.
- End of word: done=1 for exactly the final cycle of bit WIDTH-1 (counted in send order). Then:
  - If the holding register is full, its word moves to the shift register and its first bit is on x the next cycle (no gap). The holding register is freed and load_ready returns to 1 in that next cycle.
  - If the holding register is empty and no load is accepted, the next cycle has x=0, x_valid=0, busy=0.
- Full condition: with both entries occupied, load_ready=0. load_valid is ignored and din is not sampled.
- busy: 1 whenever the shift register or the holding register is occupied.
- Idle state: x is driven 0 whenever x_valid=0.
- FSM states:
  - IDLE goes to SHIFT on accept.
  - SHIFT stays in SHIFT at end of word if the holding register is full or a load is accepted in that cycle.
  - SHIFT goes to IDLE at end of word otherwise.
  - rst forces IDLE from any state.

Decomposition:
- Shared package pattern_pkg holds:
  - default WIDTH and BIT_CYCLES constants
  - the state enum (IDLE, SHIFT)
  - the MSB_FIRST encoding constants
- One sub-module is natural: pattern_bit_timer. It contains the BIT_CYCLES cycle counter and outputs a bit_end strobe. Its inputs are clk, rst and enable.

Test Plan:
1. Reset: hold rst=1 for 3 cycles with load_valid=1 -> x=0, x_valid=0, busy=0, done=0, load_ready=1 throughout, and no word accepted.
2. Single word, BIT_CYCLES=1, MSB_FIRST=1, din=32'hF6D35BDB -> x over 32 cycles is 1111 0110 1101 0011 0101 1011 1101 1011. x_valid=1 for exactly 32 cycles. done=1 only in cycle 32. busy=0 the next cycle.
3. Back-to-back: accept 32'hAAAAAAAA, then 32'h0000FFFF one cycle later -> load_ready=0 from cycle 2 until the handoff. x_valid stays high for 64 consecutive cycles. done pulses at cycles 32 and 64.
4. BIT_CYCLES=3, WIDTH=8, MSB_FIRST=0, din=8'h96 -> x is 0,1,1,0,1,0,0,1, each bit held 3 cycles. x_valid=1 for 24 cycles. done=1 in cycle 24 only.
5. Load at boundary: holding register empty, load_valid asserted in the done cycle with din=8'h5A -> the word is accepted, its first bit is on x the next cycle, and there is no x_valid gap.
6. Mid-word reset: assert rst at bit 10 of a 32-bit word with a second word held -> outputs return to reset values the next cycle. No done pulse. Neither word is ever sent.
